// File: rtl/m_led_pattern.sv
// Four-LED pattern animator: steps one pattern position per w_tick, and a
// debounced push button cycles through the four patterns.
module m_led_pattern #(
  parameter int unsigned DEBOUNCE = 2000000,
  parameter int unsigned DB_W     = 32
) (
  input  logic       w_clk,
  input  logic       w_rst,
  input  logic       w_tick,
  input  logic       w_btn,
  output logic [3:0] w_led,
  output logic [1:0] w_mode
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DN = 1'b1} dir_e;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

  logic            sync1, s_btn;
  logic            db_level, db_prev;
  logic [DB_W-1:0] db_cnt;
  logic            press;
  dir_e            dir, dir_nxt;
  logic [3:0]      led_nxt;
  logic [1:0]      mode_nxt;

  // w_btn is asynchronous; two flops before anything looks at it
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      sync1    <= 1'b0;
      s_btn    <= 1'b0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1   <= w_btn;
      s_btn   <= sync1;
      db_prev <= db_level;
      if (s_btn != db_level) begin
        if (db_cnt == DB_LAST) begin
          db_level <= s_btn;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Rising edge of the debounced level; both terms are flops
  assign press = db_level & ~db_prev;

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      w_led  <= 4'b0000;
      w_mode <= 2'd0;
      dir    <= DIR_UP;
    end else begin
      w_led  <= led_nxt;
      w_mode <= mode_nxt;
      dir    <= dir_nxt;
    end
  end

  // A press reloads the pattern and swallows any tick in the same cycle
  always_comb begin
    led_nxt  = w_led;
    mode_nxt = w_mode;
    dir_nxt  = dir;
    if (press) begin
      mode_nxt = w_mode + 2'd1;
      case (mode_nxt)
        2'd0, 2'd1: led_nxt = 4'b0000;
        2'd2:       led_nxt = 4'b0001;
        default: begin
          led_nxt = 4'b0001;
          dir_nxt = DIR_UP;
        end
      endcase
    end else if (w_tick) begin
      case (w_mode)
        2'd0: led_nxt = ~w_led;
        2'd1: led_nxt = w_led + 4'd1;
        2'd2: led_nxt = {w_led[2:0], w_led[3]};
        default: begin
          if (dir == DIR_UP) begin
            led_nxt = {w_led[2:0], 1'b0};
            if (led_nxt == 4'b1000) dir_nxt = DIR_DN;
          end else begin
            led_nxt = {1'b0, w_led[3:1]};
            if (led_nxt == 4'b0001) dir_nxt = DIR_UP;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_led_pattern.sv
// Bench for m_led_pattern: per-cycle compare against a behavioural model
// plus directed scenarios with hand-computed LED/mode values.
module tb_m_led_pattern;

  localparam int DEBOUNCE = 4;

  logic       w_clk = 1'b0;
  logic       w_rst = 1'b1;
  logic       w_tick = 1'b0;
  logic       w_btn = 1'b0;
  logic [3:0] w_led;
  logic [1:0] w_mode;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  m_led_pattern #(.DEBOUNCE(DEBOUNCE), .DB_W(8)) dut (
    .w_clk (w_clk),
    .w_rst (w_rst),
    .w_tick(w_tick),
    .w_btn (w_btn),
    .w_led (w_led),
    .w_mode(w_mode)
  );

  always #5 w_clk = ~w_clk;

  // Model: button seen through a 2-cycle delay line, accepted after
  // DEBOUNCE consecutive differing samples; bounce is a 6-entry cycle.
  logic [3:0] bseq [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};
  logic       m_d1, m_d2, m_level, m_level_d, m_press;
  int         m_run, m_phase;
  logic [1:0] m_mode;
  logic [3:0] m_led;

  always @(posedge w_clk) begin
    if (w_rst) begin
      m_d1 = 0; m_d2 = 0; m_level = 0; m_level_d = 0; m_run = 0;
      m_mode = 0; m_led = 0; m_phase = 0;
    end else begin
      m_press   = m_level && !m_level_d;
      m_level_d = m_level;
      if (m_d2 != m_level) begin
        m_run++;
        if (m_run == DEBOUNCE) begin
          m_level = m_d2;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
      m_d2 = m_d1;
      m_d1 = w_btn;
      if (m_press) begin
        m_mode  = m_mode + 2'd1;
        m_led   = (m_mode >= 2) ? 4'b0001 : 4'b0000;
        m_phase = 0;
      end else if (w_tick) begin
        case (m_mode)
          2'd0: m_led = ~m_led;
          2'd1: m_led = 4'((m_led + 1) % 16);
          2'd2: m_led = (m_led == 4'b1000) ? 4'b0001 : 4'(m_led * 2);
          default: begin
            m_phase = (m_phase + 1) % 6;
            m_led   = bseq[m_phase];
          end
        endcase
      end
    end
  end

  always @(negedge w_clk) begin
    if (started) begin
      checks++;
      if (w_led !== m_led || w_mode !== m_mode) begin
        errors++;
        $display("FAIL model t=%0t led=%b mode=%0d expected led=%b mode=%0d",
                 $time, w_led, w_mode, m_led, m_mode);
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge w_clk);
  endtask

  task automatic tick();
    w_tick = 1'b1;
    @(negedge w_clk);
    w_tick = 1'b0;
  endtask

  // Button high for 'hi' cycles then low long enough to be released;
  // optionally a tick lands on the edge where the press takes effect.
  task automatic push(input int hi, input bit with_tick);
    for (int i = 0; i < hi + 10; i++) begin
      w_btn  = (i < hi);
      w_tick = with_tick && (i == 6);
      @(negedge w_clk);
    end
    w_tick = 1'b0;
  endtask

  initial begin
    @(negedge w_clk);
    @(negedge w_clk);
    w_rst = 1'b0;
    chk("reset_led", w_led, 4'b0000);
    chk("reset_mode", {2'b00, w_mode}, 4'd0);
    started = 1'b1;

    // mode0 blink
    tick(); chk("blink1", w_led, 4'b1111);
    tick(); chk("blink2", w_led, 4'b0000);
    tick(); chk("blink3", w_led, 4'b1111);
    chk("blink_mode", {2'b00, w_mode}, 4'd0);

    // mode1 count, including the 1111 -> 0000 wrap
    push(6, 0);
    chk("mode1", {2'b00, w_mode}, 4'd1);
    chk("mode1_load", w_led, 4'b0000);
    for (int i = 1; i <= 17; i++) begin
      tick();
      chk("count", w_led, 4'(i % 16));
    end
    repeat (4) tick();
    chk("count_0101", w_led, 4'b0101);

    // press coincident with tick: pattern loads, tick dropped
    push(6, 1);
    chk("press_tick_mode", {2'b00, w_mode}, 4'd2);
    chk("press_tick_led", w_led, 4'b0001);

    // mode3 bounce
    push(6, 0);
    chk("mode3", {2'b00, w_mode}, 4'd3);
    chk("mode3_load", w_led, 4'b0001);
    begin
      logic [3:0] exp_b [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                4'b0010, 4'b0001, 4'b0010, 4'b0100};
      for (int i = 0; i < 8; i++) begin
        tick();
        chk("bounce", w_led, exp_b[i]);
      end
    end

    // reset mid-bounce
    w_rst = 1'b1;
    @(negedge w_clk);
    w_rst = 1'b0;
    chk("rst_led", w_led, 4'b0000);
    chk("rst_mode", {2'b00, w_mode}, 4'd0);
    tick(); chk("rst_tick", w_led, 4'b1111);

    // four presses wrap the mode
    push(6, 0); chk("wrap1", {2'b00, w_mode}, 4'd1);
    push(6, 0); chk("wrap2", {2'b00, w_mode}, 4'd2);
    push(6, 0); chk("wrap3", {2'b00, w_mode}, 4'd3);
    push(6, 0); chk("wrap0", {2'b00, w_mode}, 4'd0);

    // chatter shorter than the debounce window
    for (int i = 0; i < 8; i++) begin
      w_btn = ((i / 2) % 2 == 0);
      @(negedge w_clk);
    end
    w_btn = 1'b0;
    idle(10);
    chk("chatter", {2'b00, w_mode}, 4'd0);
    push(3, 0);
    chk("short_hi", {2'b00, w_mode}, 4'd0);
    push(8, 0);
    chk("long_hi", {2'b00, w_mode}, 4'd1);

    // reset mid-debounce with button held: one press after reset
    w_btn = 1'b1;
    idle(3);
    w_rst = 1'b1;
    @(negedge w_clk);
    w_rst = 1'b0;
    chk("rst_db_mode", {2'b00, w_mode}, 4'd0);
    idle(12);
    w_btn = 1'b0;
    idle(10);
    chk("held_after_rst", {2'b00, w_mode}, 4'd1);

    started = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
